// File: rtl/reg_wr_arb.sv
// Two-requester register write arbiter: host and engine-config requesters share one
// register write bus. One transaction outstanding at a time; round-robin on contention;
// each write completes on reg_ack or on a bounded wait with an error completion.
module reg_wr_arb #(
  parameter int unsigned C_ADDR_WIDTH = 10,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT    = 16  // legal 2..255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // host requester
  input  logic                    h_valid,
  output logic                    h_ready,
  input  logic [C_ADDR_WIDTH-1:0] h_addr,
  input  logic [C_DATA_WIDTH-1:0] h_data,
  output logic                    h_done,
  output logic                    h_err,
  // engine-config requester
  input  logic                    e_valid,
  output logic                    e_ready,
  input  logic [C_ADDR_WIDTH-1:0] e_addr,
  input  logic [C_DATA_WIDTH-1:0] e_data,
  output logic                    e_done,
  output logic                    e_err,
  // register write bus
  output logic [C_ADDR_WIDTH-1:0] reg_data_addr,
  output logic [C_DATA_WIDTH-1:0] reg_data,
  output logic                    reg_data_write,
  input  logic                    reg_ack,
  output logic                    grant_eng
);

  localparam int unsigned CntWidth = 8;
  // Timeout fires on the WAIT cycle whose increment would bring the counter to C_TIMEOUT-1.
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(C_TIMEOUT - 2);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                   state_q, state_d;
  logic [CntWidth-1:0]      cnt_q, cnt_d;
  logic                     grant_q;
  logic [C_ADDR_WIDTH-1:0]  addr_q;
  logic [C_DATA_WIDTH-1:0]  data_q;
  logic                     h_done_q, h_err_q, e_done_q, e_err_q;
  logic                     hs_h, hs_e, timeout, finish;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs_h || hs_e) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (finish) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready outputs: only in IDLE, contention resolved away from the last owner
  always_comb begin
    h_ready = 1'b0;
    e_ready = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (h_valid && e_valid) begin
        h_ready = grant_q;
        e_ready = !grant_q;
      end else begin
        h_ready = h_valid;
        e_ready = e_valid;
      end
    end
  end

  assign hs_h    = h_valid & h_ready;
  assign hs_e    = e_valid & e_ready;
  assign timeout = (state_q == StWait) && (cnt_q == CntLast);
  // reg_ack takes priority over timeout; both end the transaction
  assign finish  = (state_q == StWait) && (reg_ack || timeout);

  // Wait counter next value: cleared on issue, counts WAIT cycles without ack
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if ((state_q == StWait) && !reg_ack) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  // Datapath: capture on handshake, completion flags registered one cycle after WAIT exit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      grant_q  <= 1'b1;  // host wins the first contention
      addr_q   <= '0;
      data_q   <= '0;
      h_done_q <= 1'b0;
      h_err_q  <= 1'b0;
      e_done_q <= 1'b0;
      e_err_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (hs_h || hs_e) begin
        grant_q <= hs_e;
        addr_q  <= hs_e ? e_addr : h_addr;
        data_q  <= hs_e ? e_data : h_data;
      end
      h_done_q <= finish && !grant_q;
      h_err_q  <= finish && !grant_q && !reg_ack;
      e_done_q <= finish && grant_q;
      e_err_q  <= finish && grant_q && !reg_ack;
    end
  end

  assign reg_data_write = (state_q == StIssue);
  assign reg_data_addr  = addr_q;
  assign reg_data       = data_q;
  assign grant_eng      = grant_q;
  assign h_done         = h_done_q;
  assign h_err          = h_err_q;
  assign e_done         = e_done_q;
  assign e_err          = e_err_q;

endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: a transaction-level model predicts grants, strobes and
// completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_reg_wr_arb;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic h_valid, h_ready, h_done, h_err, e_valid, e_ready, e_done, e_err;
  logic [AW-1:0] h_addr, e_addr, reg_data_addr;
  logic [DW-1:0] h_data, e_data, reg_data;
  logic reg_data_write, reg_ack, grant_eng;

  always #5 clk = ~clk;

  reg_wr_arb #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_data(h_data),
    .h_done(h_done), .h_err(h_err),
    .e_valid(e_valid), .e_ready(e_ready), .e_addr(e_addr), .e_data(e_data),
    .e_done(e_done), .e_err(e_err),
    .reg_data_addr(reg_data_addr), .reg_data(reg_data), .reg_data_write(reg_data_write),
    .reg_ack(reg_ack), .grant_eng(grant_eng)
  );

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; bit eng; int unsigned cyc;} wr_t;
  typedef struct {bit eng; bit err; int unsigned cyc;} dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t mw;
  dn_t md;
  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned rst_cnt = 0;

  // stimulus/model state
  bit rst_req = 1'b0;
  bit h_pend = 1'b0, e_pend = 1'b0, h_fix = 1'b0;
  bit model_last = 1'b1;  // 1: engine owned last grant
  int unsigned idle_from = 0, ack_at = 0, last_s = 0;
  bit ack_armed = 1'b0, stray_en = 1'b0;
  int h_left = 0, e_left = 0, prob = 100, force_d = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_cnt <= rst_n ? 0 : rst_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare DUT outputs against scoreboard queues
  always @(negedge clk) begin
    chk("both_ready", 64'(h_ready & e_ready), 64'(0));
    if (!rst_n) begin
      chk("ready_in_reset", 64'({h_ready, e_ready}), 64'(0));
      if (rst_cnt >= 1)
        chk("outs_in_reset",
            64'({reg_data_write, h_done, h_err, e_done, e_err, grant_eng, reg_data_addr, reg_data}),
            {16'h0, 6'b000001, 42'h0});
    end else begin
      chk("err_qualified", 64'({h_err & ~h_done, e_err & ~e_done}), 64'(0));
      if (reg_data_write) begin
        if (wq.size() == 0) chk("spurious_strobe", 64'(1), 64'(0));
        else begin
          mw = wq.pop_front();
          chk("strobe_cycle", 64'(cyc), 64'(mw.cyc));
          chk("strobe_addr", 64'(reg_data_addr), 64'(mw.addr));
          chk("strobe_data", 64'(reg_data), 64'(mw.data));
          chk("strobe_owner", 64'(grant_eng), 64'(mw.eng));
        end
      end
      if (h_done || e_done) begin
        if (dq.size() == 0) chk("spurious_done", 64'({h_done, e_done}), 64'(0));
        else begin
          md = dq.pop_front();
          chk("done_side", 64'({h_done, e_done}), md.eng ? 64'(1) : 64'(2));
          chk("done_err", 64'(e_done ? e_err : h_err), 64'(md.err));
          chk("done_cycle", 64'(cyc), 64'(md.cyc));
        end
      end
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("missing_strobe", 64'(0), 64'(wq[0].cyc));
        void'(wq.pop_front());
      end
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk("missing_done", 64'(0), 64'(dq[0].cyc));
        void'(dq.pop_front());
      end
    end
  end

  // Arbitration model: decide who should be ready, and predict the transaction outcome
  task automatic arbitrate();
    bit exp_h, exp_e;
    int unsigned s, d;
    exp_h = 1'b0;
    exp_e = 1'b0;
    if (cyc >= idle_from) begin
      if (h_valid && e_valid) begin
        if (model_last) exp_h = 1'b1;
        else exp_e = 1'b1;
      end else if (h_valid) exp_h = 1'b1;
      else if (e_valid) exp_e = 1'b1;
    end
    if (h_valid || e_valid) chk("ready", 64'({h_ready, e_ready}), 64'({exp_h, exp_e}));
    if (exp_h || exp_e) begin
      model_last = exp_e;
      s = cyc + 1;
      last_s = s;
      d = (force_d > 0) ? force_d : $urandom_range(1, TO + 1);
      ack_at = s + d;
      ack_armed = 1'b1;
      wq.push_back('{addr: exp_e ? e_addr : h_addr, data: exp_e ? e_data : h_data,
                     eng: exp_e, cyc: s});
      if (d <= TO - 1) begin
        dq.push_back('{eng: exp_e, err: 1'b0, cyc: s + d + 1});
        idle_from = s + d + 1;
      end else begin
        dq.push_back('{eng: exp_e, err: 1'b1, cyc: s + TO});
        idle_from = s + TO;
      end
    end
    if (h_valid && h_ready) h_pend = 1'b0;
    if (e_valid && e_ready) e_pend = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_req && rst_n) begin
      wq.delete();
      dq.delete();
      idle_from = 0;
      model_last = 1'b1;
      h_pend = 1'b0;
      e_pend = 1'b0;
      ack_armed = 1'b0;
    end
    rst_n = rst_req;
    reg_ack = ack_armed && (cyc == ack_at);
    if (stray_en && rst_n && cyc >= idle_from && $urandom_range(0, 5) == 0) reg_ack = 1'b1;
    if (!h_pend) begin
      if (!h_fix) begin
        h_addr = AW'($urandom);
        h_data = $urandom;
      end
      if (h_left > 0 && $urandom_range(0, 99) < prob) begin
        h_pend = 1'b1;
        h_left--;
      end
    end
    if (!e_pend) begin
      e_addr = AW'($urandom);
      e_data = $urandom;
      if (e_left > 0 && $urandom_range(0, 99) < prob) begin
        e_pend = 1'b1;
        e_left--;
      end
    end
    h_valid = h_pend;
    e_valid = e_pend;
    @(negedge clk);
    if (rst_n) arbitrate();
  endtask

  task automatic run_until_idle();
    int n;
    n = 0;
    while ((h_pend || e_pend || h_left > 0 || e_left > 0 || cyc <= idle_from) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 64'(n), 64'(0));
  endtask

  initial begin
    int n;
    h_valid = 0; e_valid = 0; reg_ack = 0;
    h_addr = '0; h_data = '0; e_addr = '0; e_data = '0;
    rst_req = 1'b0;
    repeat (3) step();
    rst_req = 1'b1;
    repeat (2) step();

    // both contend from reset, immediate ack: H,E,H,E,H,E
    h_left = 3; e_left = 3; prob = 100; force_d = 1;
    run_until_idle();

    // host only, fixed payload, ack two cycles after strobe
    h_fix = 1'b1; h_addr = 10'h004; h_data = 32'hDEAD_BEEF;
    h_left = 1; force_d = 2;
    run_until_idle();
    h_fix = 1'b0;

    // engine timeouts, second request accepted in the done cycle
    e_left = 2; force_d = TO + 1;
    run_until_idle();

    // ack in the timeout cycle wins; then stray acks while idle
    e_left = 1; force_d = TO - 1;
    run_until_idle();
    stray_en = 1'b1;
    repeat (20) step();
    stray_en = 1'b0;

    // reset during WAIT, ack after release must be ignored
    h_left = 1; force_d = 100;
    n = 0;
    while ((h_left > 0 || h_pend) && n < 50) begin step(); n++; end
    n = 0;
    while (cyc < last_s + 2 && n < 50) begin step(); n++; end
    rst_req = 1'b0;
    step();
    step();
    rst_req = 1'b1;
    step();
    ack_at = cyc + 2;
    ack_armed = 1'b1;
    repeat (4) step();
    h_left = 1; e_left = 1; force_d = 1;
    run_until_idle();

    // random stress
    h_left = 1000000; e_left = 1000000; prob = 40; force_d = 0; stray_en = 1'b1;
    repeat (10000) step();
    h_left = 0; e_left = 0; stray_en = 1'b0;
    run_until_idle();
    repeat (3) step();

    chk("wq_drained", 64'(wq.size()), 64'(0));
    chk("dq_drained", 64'(dq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
